cu_csr_master: RTL

- Initiator end of the com_csr_if CSR bus. Converts single-beat requests from a host/command source into CSR bus transactions, and returns read data or an error per request.
- Sits between the host bridge or command sequencer and any com_csr_if slave, for example cu_csr_slave.
- One outstanding transaction.
- Includes a bus timeout, an alignment check and saturating status counters.

---
 rtl/cu_csr_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cu_csr_master.sv
// CSR bus initiator: turns single-beat host requests into CSR bus transfers,
// with alignment check, bus timeout and saturating status counters.
module cu_csr_master #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 256,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [SW-1:0] req_wstrb,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          csr_write,
  output logic [AW-1:0] csr_addr,
  output logic [DW-1:0] csr_wdata,
  output logic [SW-1:0] csr_wstrb,
  output logic          csr_valid,
  input  logic          csr_ready,
  input  logic [DW-1:0] csr_rdata,
  output logic          sta_busy,
  output logic [CW-1:0] sta_txn_cnt,
  output logic [CW-1:0] sta_err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int          TL       = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMO_LAST = TW'(TL);

  logic [1:0]    state_q, state_d;
  logic          csr_valid_q, csr_valid_d;
  logic          csr_write_q, csr_write_d;
  logic [AW-1:0] csr_addr_q, csr_addr_d;
  logic [DW-1:0] csr_wdata_q, csr_wdata_d;
  logic [SW-1:0] csr_wstrb_q, csr_wstrb_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] txn_cnt_q, txn_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          misaligned;

  assign misaligned = (req_addr & AW'(SW - 1)) != '0;

  always_comb begin
    state_d     = state_q;
    csr_valid_d = csr_valid_q;
    csr_write_d = csr_write_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    csr_wstrb_d = csr_wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = tmo_q;
    txn_cnt_d   = txn_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (clear) begin
      // Soft clear drops any pending transfer or response; counters survive.
      state_d     = S_IDLE;
      csr_valid_d = 1'b0;
      csr_write_d = 1'b0;
      csr_addr_d  = '0;
      csr_wdata_d = '0;
      csr_wstrb_d = '0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      tmo_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            csr_write_d = req_write;
            csr_addr_d  = req_addr;
            csr_wdata_d = req_write ? req_wdata : '0;
            csr_wstrb_d = req_write ? req_wstrb : '0;
            tmo_d       = '0;
            if (misaligned) begin
              state_d     = S_RSP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = '0;
            end else begin
              state_d     = S_BUS;
              csr_valid_d = 1'b1;
            end
          end
        end
        S_BUS: begin
          // csr_ready wins over a timeout landing on the same cycle.
          if (csr_ready) begin
            state_d     = S_RSP;
            csr_valid_d = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = csr_write_q ? '0 : csr_rdata;
          end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
            state_d     = S_RSP;
            csr_valid_d = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (TIMEOUT != 0) begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
            if (txn_cnt_q != '1) txn_cnt_d = txn_cnt_q + CW'(1);
            if (rsp_err_q && err_cnt_q != '1) err_cnt_d = err_cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      csr_valid_q <= 1'b0;
      csr_write_q <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      csr_wstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      txn_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      csr_valid_q <= csr_valid_d;
      csr_write_q <= csr_write_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      csr_wstrb_q <= csr_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      txn_cnt_q   <= txn_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign csr_valid   = csr_valid_q;
  assign csr_write   = csr_write_q;
  assign csr_addr    = csr_addr_q;
  assign csr_wdata   = csr_wdata_q;
  assign csr_wstrb   = csr_wstrb_q;
  assign sta_busy    = busy_q;
  assign sta_txn_cnt = txn_cnt_q;
  assign sta_err_cnt = err_cnt_q;

endmodule
